// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and default widths for the SRAM-port arbiter.
package sram_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Current owner of the downstream port
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } arb_gnt_e;

  // Transfer size encodings
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and memory-side SRAM-like handshake signals of the arbiter.
// slave: arbiter view; master: environment (core requesters + memory) view.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [STRB_W-1:0] data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational requester picker. Data wins ties by default; with
// SRAM_ARB_RR_EN defined, ties go to the requester not granted last.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic     i_inst_req,
  input  logic     i_data_req,
`ifdef SRAM_ARB_RR_EN
  input  arb_gnt_e i_last_grant,
`endif
  output arb_gnt_e o_next_grant_c
);

  // Pick the next owner from the live requests
  always_comb begin
    o_next_grant_c = GNT_INST;
    if (i_inst_req && i_data_req) begin
`ifdef SRAM_ARB_RR_EN
      o_next_grant_c = (i_last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
`else
      o_next_grant_c = GNT_DATA;
`endif
    end else if (i_data_req) begin
      o_next_grant_c = GNT_DATA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters, one
// transaction outstanding. Optional SRAM_ARB_RR_EN selects round-robin ties.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_gnt_e   r_grant;
  arb_gnt_e   w_grant_nxt;
  arb_gnt_e   w_pick;
  logic       w_any_req;

`ifdef SRAM_ARB_RR_EN
  arb_gnt_e   r_last_grant;
`endif

  assign w_any_req = bus.inst_req | bus.data_req;

  sram_arb_pick u_pick (
    .i_inst_req     (bus.inst_req),
    .i_data_req     (bus.data_req),
`ifdef SRAM_ARB_RR_EN
    .i_last_grant   (r_last_grant),
`endif
    .o_next_grant_c (w_pick)
  );

  // State and grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= GNT_INST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember the owner of every new grant for tie-breaking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_INST;
    end else if (r_state != ARB_REQ && w_state_nxt == ARB_REQ) begin
      r_last_grant <= w_grant_nxt;
    end
  end
`endif

  // Next state, request mux and response routing
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    bus.mem_req      = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_size     = 2'd0;
    bus.mem_addr     = '0;
    bus.mem_wstrb    = '0;
    bus.mem_wdata    = '0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;

    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ARB_REQ;
        end
      end

      ARB_REQ: begin
        bus.mem_req = 1'b1;
        if (r_grant == GNT_DATA) begin
          bus.mem_wr    = bus.data_wr;
          bus.mem_size  = bus.data_size;
          bus.mem_addr  = bus.data_addr;
          bus.mem_wstrb = bus.data_wstrb;
          bus.mem_wdata = bus.data_wdata;
        end else begin
          bus.mem_size  = SIZE_W;
          bus.mem_addr  = bus.inst_addr;
        end
        if (bus.mem_addr_ok) begin
          if (r_grant == GNT_DATA) begin
            bus.data_addr_ok = 1'b1;
          end else begin
            bus.inst_addr_ok = 1'b1;
          end
          w_state_nxt = ARB_RESP;
        end
      end

      ARB_RESP: begin
        if (bus.mem_data_ok) begin
          if (r_grant == GNT_DATA) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = bus.mem_rdata;
          end else begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = bus.mem_rdata;
          end
          // Back-to-back: re-arbitrate without passing through IDLE
          if (w_any_req) begin
            w_grant_nxt = w_pick;
            w_state_nxt = ARB_REQ;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end

      default: w_state_nxt = ARB_IDLE;
    endcase
  end

endmodule
